// File: rtl/qam_pkg.sv
// ---------------------------------------------------------------------------
// qam_pkg
// Shared types and helpers for the 16-QAM receive slicer.
//   SYM_W   : width of a recovered symbol (2 bits per axis)
//   DATA_W  : default width of the signed demodulated samples
//   level_t : the four 16-QAM amplitude levels on one axis
//   slice() : decide the level of one axis sample against +/-thresh and 0
//   gray2() : Gray code of a level, so neighbouring levels differ in one bit
// ---------------------------------------------------------------------------
package qam_pkg;

    localparam int SYM_W  = 4;
    localparam int DATA_W = 18;

    typedef enum logic [1:0] {
        LVL_M3 = 2'd0,
        LVL_M1 = 2'd1,
        LVL_P1 = 2'd2,
        LVL_P3 = 2'd3
    } level_t;

    // Samples are sign-extended to 32 bits by the caller, so the compare
    // gives the same result as a signed compare at the sample width.
    // x = 0 decides +1, x = -thresh decides -1, x = +thresh decides +3.
    function automatic level_t slice(input logic signed [31:0] x,
                                     input logic signed [31:0] thresh);
        level_t lvl;
        if (x >= thresh)
            lvl = LVL_P3;
        else if (x >= 32'sd0)
            lvl = LVL_P1;
        else if (x >= -thresh)
            lvl = LVL_M1;
        else
            lvl = LVL_M3;
        return lvl;
    endfunction

    function automatic logic [1:0] gray2(input level_t lvl);
        logic [1:0] g;
        case (lvl)
            LVL_M3:  g = 2'b00;
            LVL_M1:  g = 2'b01;
            LVL_P1:  g = 2'b11;
            LVL_P3:  g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/qam16_slicer_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft
// Small single-clock first-word-fall-through FIFO.
//   axi_clk, axi_rst : clock and synchronous active-high reset
//   wr_en, din, full : write side; a write while full is accepted only when
//                      a read happens in the same cycle
//   rd_en, dout, empty : read side; dout shows the head entry whenever
//                      empty=0, and reads 0 while empty; rd_en while empty
//                      is ignored
// DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module sync_fifo_fwft #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             axi_clk,
    input  logic             axi_rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic do_wr;
    logic do_rd;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // Full implies non-empty, so a read in the same cycle frees the slot
    // that the write is about to fill.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Head entry is read straight from the array so a freshly written word
    // is visible the cycle after its write (fall-through). Gated to 0 while
    // empty so the output is defined out of reset.
    assign dout = empty ? '0 : mem[rd_ptr_reg];

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge axi_clk) begin
        if (do_wr)
            mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_rd)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/qam16_slicer.sv
// ---------------------------------------------------------------------------
// qam16_slicer
// Recovers 16-QAM symbols from the oversampled demodulated I/Q stream:
// picks one sample per symbol at a programmable phase, slices each axis to
// a level, Gray-maps it and queues the 4-bit symbol behind valid/ready.
//   axi_clk, axi_rst    : clock, synchronous active-high reset
//   demult_valid        : input sample strobe
//   demult_i, demult_q  : signed I/Q samples
//   sample_phase        : index within the symbol period to decide on
//   dout_valid, dout    : recovered symbol ([3:2] from I, [1:0] from Q)
//   dout_ready          : consumer accepts the symbol shown on dout
//   overflow            : sticky, a symbol was dropped on a full queue
//   sym_count           : symbols accepted into the queue, wrapping
// Latency: capture in cycle N, decision register in N+1, queue write on
// the N+1 edge, symbol on dout in N+2 when the queue was empty.
// ---------------------------------------------------------------------------
module qam16_slicer #(
    parameter int DATA_W     = qam_pkg::DATA_W,
    parameter int OSR        = 8,
    parameter int THRESH     = 16384,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    axi_clk,
    input  logic                    axi_rst,
    input  logic                    demult_valid,
    input  logic signed [DATA_W-1:0] demult_i,
    input  logic signed [DATA_W-1:0] demult_q,
    input  logic [$clog2(OSR)-1:0]  sample_phase,
    output logic                    dout_valid,
    output logic [3:0]              dout,
    input  logic                    dout_ready,
    output logic                    overflow,
    output logic [15:0]             sym_count
);

    import qam_pkg::*;

    localparam int PH_W = $clog2(OSR);

    logic [PH_W-1:0]  phase_cnt_reg;
    logic             capture;
    logic [SYM_W-1:0] sym_next;
    logic             dec_valid_reg;
    logic [SYM_W-1:0] dec_sym_reg;
    logic             overflow_reg;
    logic [15:0]      sym_count_reg;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_rd;
    logic             fifo_accept;
    logic             fifo_drop;
    logic [SYM_W-1:0] fifo_dout;

    // Counts valid samples within a symbol; OSR is a power of two so the
    // natural wrap gives modulo OSR. Any gap restarts the symbol at index 0,
    // which also throws away a partially received symbol.
    always_ff @(posedge axi_clk) begin
        if (axi_rst)
            phase_cnt_reg <= '0;
        else if (demult_valid)
            phase_cnt_reg <= phase_cnt_reg + PH_W'(1);
        else
            phase_cnt_reg <= '0;
    end

    assign capture = demult_valid && (phase_cnt_reg == sample_phase);

    // Per-axis slicer: index 1 is I (symbol bits [3:2]), index 0 is Q.
    logic signed [DATA_W-1:0] axis_x [2];
    assign axis_x[1] = demult_i;
    assign axis_x[0] = demult_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
        logic signed [31:0] axis_ext;
        assign axis_ext = 32'(axis_x[gi]);
        assign sym_next[2*gi +: 2] = gray2(slice(axis_ext, THRESH));
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            dec_valid_reg <= 1'b0;
            dec_sym_reg   <= '0;
        end else begin
            dec_valid_reg <= capture;
            if (capture)
                dec_sym_reg <= sym_next;
        end
    end

    // A read only happens while a symbol is shown, so ready on an empty
    // queue has no effect.
    assign dout_valid = !fifo_empty;
    assign dout       = fifo_dout;
    assign fifo_rd    = dout_valid && dout_ready;

    // Mirrors the queue's own accept rule: a full queue takes a new symbol
    // only when the head leaves in the same cycle.
    assign fifo_accept = dec_valid_reg && (!fifo_full || fifo_rd);
    assign fifo_drop   = dec_valid_reg && fifo_full && !fifo_rd;

    sync_fifo_fwft #(
        .WIDTH (SYM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .axi_clk (axi_clk),
        .axi_rst (axi_rst),
        .wr_en   (dec_valid_reg),
        .din     (dec_sym_reg),
        .full    (fifo_full),
        .rd_en   (fifo_rd),
        .dout    (fifo_dout),
        .empty   (fifo_empty)
    );

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            overflow_reg  <= 1'b0;
            sym_count_reg <= '0;
        end else begin
            if (fifo_drop)
                overflow_reg <= 1'b1;
            if (fifo_accept)
                sym_count_reg <= sym_count_reg + 16'd1;
        end
    end

    assign overflow  = overflow_reg;
    assign sym_count = sym_count_reg;

endmodule

// File: tb/tb_qam16_slicer.sv
// ---------------------------------------------------------------------------
// tb_qam16_slicer
// Directed bench for qam16_slicer. Expected symbols are pushed to a queue
// when the sample that should be captured is driven; a negedge monitor pops
// and compares on every output transfer and checks that dout holds while
// stalled. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_qam16_slicer;

    localparam int DATA_W = 18;
    localparam int OSR    = 8;

    logic                     axi_clk = 1'b0;
    logic                     axi_rst;
    logic                     demult_valid;
    logic signed [DATA_W-1:0] demult_i;
    logic signed [DATA_W-1:0] demult_q;
    logic [2:0]               sample_phase;
    logic                     dout_valid;
    logic [3:0]               dout;
    logic                     dout_ready;
    logic                     overflow;
    logic [15:0]              sym_count;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_xfer = 0;

    logic [3:0] exp_q [$];

    logic       held = 1'b0;
    logic [3:0] held_dout = 4'd0;

    always #5 axi_clk = ~axi_clk;

    qam16_slicer #(
        .DATA_W     (DATA_W),
        .OSR        (OSR),
        .THRESH     (16384),
        .FIFO_DEPTH (4)
    ) dut (
        .axi_clk      (axi_clk),
        .axi_rst      (axi_rst),
        .demult_valid (demult_valid),
        .demult_i     (demult_i),
        .demult_q     (demult_q),
        .sample_phase (sample_phase),
        .dout_valid   (dout_valid),
        .dout         (dout),
        .dout_ready   (dout_ready),
        .overflow     (overflow),
        .sym_count    (sym_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference: level decision and Gray code per axis.
    function automatic logic [1:0] ref_axis(input int x);
        if (x >= 16384)       return 2'b10;
        else if (x >= 0)      return 2'b11;
        else if (x >= -16384) return 2'b01;
        else                  return 2'b00;
    endfunction

    function automatic logic [3:0] ref_sym(input int i, input int q);
        return {ref_axis(i), ref_axis(q)};
    endfunction

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            demult_valid = 1'b0;
        end
    endtask

    // One full symbol period of constant I/Q; the expected symbol is
    // queued as the capture-index sample is driven.
    task automatic send_period(input int i, input int q, input logic keep);
        for (int k = 0; k < OSR; k++) begin
            tick();
            demult_valid = 1'b1;
            demult_i     = DATA_W'(i);
            demult_q     = DATA_W'(q);
            if (keep && k == int'(sample_phase))
                exp_q.push_back(ref_sym(i, q));
        end
    endtask

    task automatic do_reset();
        tick();
        axi_rst      = 1'b1;
        demult_valid = 1'b0;
        tick();
        axi_rst = 1'b0;
        exp_q.delete();
    endtask

    // Scoreboard monitor and stall-stability check.
    always @(negedge axi_clk) begin
        if (axi_rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 32'(dout_valid), 32'd1);
                chk("hold_dout", 32'(dout), 32'(held_dout));
            end
            if (dout_valid && dout_ready) begin
                n_xfer++;
                n_cmp++;
                assert (exp_q.size() != 0)
                else begin
                    n_bad++;
                    $error("FAIL unexpected_sym: observed %0h expected none", dout);
                end
                if (exp_q.size() != 0)
                    chk("sym", 32'(dout), 32'(exp_q.pop_front()));
            end
            held      = dout_valid && !dout_ready;
            held_dout = dout;
        end
    end

    int sc0;
    int x0;
    int ri;
    int rq;

    initial begin
        axi_rst      = 1'b1;
        demult_valid = 1'b0;
        demult_i     = '0;
        demult_q     = '0;
        sample_phase = 3'd3;
        dout_ready   = 1'b0;

        // Reset values
        tick();
        @(negedge axi_clk);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_count", 32'(sym_count), 32'd0);
        tick();
        axi_rst = 1'b0;

        // Constant input, phase 3, always ready
        dout_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            demult_valid = 1'b1;
            demult_i     = 18'sd20000;
            demult_q     = -18'sd20000;
            if (k % OSR == 3)
                exp_q.push_back(4'b1000);
            @(negedge axi_clk);
            chk("const_valid", 32'(dout_valid), 32'((k >= 5 && (k - 5) % OSR == 0) ? 1 : 0));
            chk("const_count", 32'(sym_count), 32'((k >= 5) ? (k - 5) / OSR + 1 : 0));
        end
        idle(4);
        @(negedge axi_clk);
        chk("const_total", 32'(sym_count), 32'd5);

        // Decision boundaries
        sample_phase = 3'd2;
        send_period(0, -16384, 1'b1);
        send_period(16384, -1, 1'b1);
        send_period(16383, -16385, 1'b1);
        idle(4);

        // Random levels at random phases, gap between symbols
        for (int n = 0; n < 8; n++) begin
            idle(1);
            sample_phase = 3'($urandom_range(0, 7));
            ri = int'($urandom_range(0, 60000)) - 30000;
            rq = int'($urandom_range(0, 60000)) - 30000;
            send_period(ri, rq, 1'b1);
        end
        idle(4);

        // Gap at index 5 with phase 7: partial symbol discarded
        sample_phase = 3'd7;
        @(negedge axi_clk);
        sc0 = int'(sym_count);
        for (int k = 0; k < 6; k++) begin
            tick();
            demult_valid = 1'b1;
            demult_i     = 18'sd20000;
            demult_q     = 18'sd20000;
        end
        idle(1);
        send_period(-20000, 5000, 1'b1);
        tick();
        demult_valid = 1'b0;
        @(negedge axi_clk);
        chk("gap_not_yet", 32'(dout_valid), 32'd0);
        tick();
        @(negedge axi_clk);
        chk("gap_emit", 32'(dout_valid), 32'd1);
        chk("gap_sym", 32'(dout), 32'(4'b0011));
        idle(3);
        @(negedge axi_clk);
        chk("gap_count", 32'(sym_count), 32'(sc0 + 1));

        // Backpressure: six symbols into a four-deep queue
        do_reset();
        dout_ready   = 1'b0;
        sample_phase = 3'd3;
        send_period(20000, 20000, 1'b1);
        send_period(-20000, -20000, 1'b1);
        send_period(5000, -5000, 1'b1);
        send_period(-5000, 5000, 1'b1);
        send_period(20000, -5000, 1'b0);
        send_period(-20000, 5000, 1'b0);
        idle(4);
        @(negedge axi_clk);
        chk("bp_overflow", 32'(overflow), 32'd1);
        chk("bp_count", 32'(sym_count), 32'd4);
        chk("bp_valid", 32'(dout_valid), 32'd1);
        chk("bp_head", 32'(dout), 32'(4'b1010));
        x0 = n_xfer;
        tick();
        dout_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
        end
        @(negedge axi_clk);
        chk("bp_drained", 32'(n_xfer - x0), 32'd4);
        chk("bp_empty", 32'(dout_valid), 32'd0);
        chk("bp_overflow_held", 32'(overflow), 32'd1);

        // Reset with three queued and overflow set
        do_reset();
        dout_ready = 1'b0;
        send_period(20000, 20000, 1'b1);
        send_period(-20000, -20000, 1'b1);
        send_period(5000, -5000, 1'b1);
        send_period(-5000, 5000, 1'b1);
        send_period(20000, -5000, 1'b0);
        idle(3);
        tick();
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        @(negedge axi_clk);
        chk("pre_rst_overflow", 32'(overflow), 32'd1);
        chk("pre_rst_valid", 32'(dout_valid), 32'd1);
        do_reset();
        @(negedge axi_clk);
        chk("post_rst_valid", 32'(dout_valid), 32'd0);
        chk("post_rst_overflow", 32'(overflow), 32'd0);
        chk("post_rst_count", 32'(sym_count), 32'd0);
        dout_ready = 1'b1;
        send_period(-5000, -20000, 1'b1);
        idle(4);
        @(negedge axi_clk);
        chk("post_rst_sym_count", 32'(sym_count), 32'd1);

        idle(4);
        @(negedge axi_clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/qam16_slicer.md
Name: qam16_slicer

Overview:
- Receive-side symbol recovery stage. Sits directly downstream of qam_top and consumes its demodulated baseband stream (demult_valid, demult_i, demult_q).
- Decimates the OSR-times oversampled I/Q stream at a programmable sampling phase, slices each axis to a 16-QAM level and Gray-demaps to a 4-bit symbol.
- Buffers recovered symbols in a small FIFO with a valid/ready output, so recovered symbols can be compared against the transmit din stream.

Parameters:
- DATA_W, 18, width of signed demult_i/demult_q.
- OSR, 8, samples per symbol; power of two, at least 2.
- THRESH, 16384, positive outer-decision threshold; inner threshold is 0.
- FIFO_DEPTH, 4, output FIFO entries; power of two.

Ports:
- axi_clk  in  1  single clock.
- axi_rst  in  1  synchronous, active-high reset.
- demult_valid  in  1  input sample strobe from qam_top.
- demult_i  in  DATA_W  signed in-phase sample.
- demult_q  in  DATA_W  signed quadrature sample.
- sample_phase  in  $clog2(OSR)  sample index within symbol to decide on; quasi-static.
- dout_valid  out  1  symbol available.
- dout  out  4  recovered symbol: [3:2] from I, [1:0] from Q.
- dout_ready  in  1  consumer accepts symbol.
- overflow  out  1  sticky; a symbol was dropped.
- sym_count  out  16  symbols written to FIFO, wraps at 65535->0.

Behaviour:
- Interface: one clock axi_clk; reset axi_rst is synchronous and active-high. All state changes occur on the rising edge of axi_clk.
- Reset values: dout_valid=0, dout=0, overflow=0, sym_count=0, phase counter=0, FIFO empty, decision register invalid.
- Phase counter:
  - Increments modulo OSR on each cycle with demult_valid=1.
  - The cycle with demult_valid=0 forces the counter to 0, so the first valid sample after a gap is index 0.
- Sample capture: capture occurs when demult_valid=1 and counter==sample_phase. sample_phase is sampled in the same cycle.
- Slicer, applied independently to I and Q, signed compare at DATA_W:
  - x >= THRESH -> +3
  - 0 <= x < THRESH -> +1
  - -THRESH <= x < 0 -> -1
  - x < -THRESH -> -3
  - Boundaries: x=0 gives +1; x=-THRESH gives -1; x=THRESH gives +3.
- Gray map per axis: -3->00, -1->01, +1->11, +3->10.
- Pipeline:
  - Cycle N: capture cycle.
  - N+1: registered decision.
  - N+1 edge: FIFO write.
  - The FIFO is first-word fall-through, so dout_valid=1 with the symbol on dout at cycle N+2 when the FIFO was empty.
- Output handshake:
  - Transfer occurs when dout_valid and dout_ready are both 1.
  - dout is held stable while dout_valid=1 and dout_ready=0.
  - dout_valid never deasserts without a transfer.
- Full FIFO behaviour:
  - Write with simultaneous read while full: accepted, occupancy unchanged.
  - Write while full with no read: symbol dropped, overflow set to 1 and held until axi_rst, sym_count not incremented.
- Empty FIFO behaviour:
  - Read only occurs when dout_valid=1; dout_ready while empty is ignored.
  - Write into empty with dout_ready=1: no same-cycle bypass; the symbol appears the next cycle.
- Continuous input: a continuous demult_valid yields exactly one symbol per OSR cycles.
- Mid-symbol deassert: demult_valid falling mid-symbol discards the partial symbol. There is no capture unless the sample_phase index was reached.
- Reset mid-operation: axi_rst clears the FIFO contents, pipeline, counter, overflow and sym_count in one cycle. A decision in flight is lost.

Decomposition:
- Package qam_pkg:
  - SYM_W=4, DATA_W=18.
  - typedef level_t enum {LVL_M3, LVL_M1, LVL_P1, LVL_P3}.
  - function slice(x, thresh) returning level_t.
  - function gray2(level_t) returning 2 bits.
- Sub-module sync_fifo_fwft:
  - Parameters WIDTH and DEPTH.
  - Ports wr_en/din/full, rd_en/dout/empty.
  - Same clock and reset.
  - Instantiated once with WIDTH=4.
- Top block contains the counter, slicer pipeline, overflow and count logic.

Test Plan:
- Constant input: demult_valid=1 continuous, I=+20000, Q=-20000, sample_phase=3, dout_ready=1. Expected: dout=4'b1000 every 8 cycles, first dout_valid 2 cycles after counter index 3; sym_count increments by 1 per symbol.
- Boundaries: per-symbol I/Q pairs (0,-16384), (16384,-1), (16383,-16385). Expected: dout=1101, 1001, 1100 respectively.
- Backpressure: dout_ready=0 for 6 symbols with FIFO_DEPTH=4. Expected: first 4 symbols retained in order; symbols 5 and 6 dropped; overflow=1; sym_count=4. Releasing dout_ready drains exactly 4 symbols.
- Gap: demult_valid drops at counter index 5, sample_phase=7. Expected: no symbol for the partial period; the next period restarts at index 0 and the symbol is emitted at its 8th valid sample.
- Reset mid-operation: axi_rst pulsed with 3 symbols queued and overflow=1. Expected: next cycle dout_valid=0, overflow=0, sym_count=0; the next symbol arrives normally.
- Loopback: 1024 random din values into qam_top feeding this block, with sample_phase tuned to the filter delay. Expected: dout sequence equals the din sequence after a fixed symbol offset, with zero mismatches.
